// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate backed by an internal word memory: fixed wait states, external stall,
// byte-lane writes selected by HSIZE, and a two-cycle ERROR response for illegal accesses.
module ahb_subordinate_mem #(
    parameter int          DATA_WDT    = 32,
    parameter int          MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'h0,
    parameter logic [31:0] ERR_SIZE    = 32'h0
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic                i_hreadyin,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_stall,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output logic [1:0]          o_hresp
);
    localparam int          BYTES     = DATA_WDT / 8;
    localparam int          LANE_W    = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic [BYTES-1:0] lane_enable(input logic [LANE_W-1:0] off,
                                                     input logic [2:0]        size);
        logic [BYTES-1:0] be;
        int span;
        span = 1 << size;
        for (int b = 0; b < BYTES; b++)
            be[b] = (b >= int'(off)) && (b < int'(off) + span);
        return be;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    state_t              state;
    logic [3:0]          wcnt;
    logic                ready_q;
    logic                resp_q;
    logic [IDX_W-1:0]    idx_p1;
    logic [BYTES-1:0]    be_p1;
    logic                write_p1;
    logic [DATA_WDT-1:0] mem [MEM_DEPTH];

    logic [63:0] rel;
    logic [63:0] erel;
    logic        in_mem;
    logic        in_err;
    logic        size_bad;
    logic        misalign;
    logic        err_a;
    logic        accept;
    logic        in_data;
    logic        mem_we;
    logic        unused_hburst;

    // Address phase decode: out-of-range addresses wrap far above MEM_BYTES
    assign rel      = {32'h0, i_haddr} - {32'h0, BASE_ADDR};
    assign erel     = {32'h0, i_haddr} - {32'h0, ERR_BASE};
    assign in_mem   = rel < MEM_BYTES;
    assign in_err   = (ERR_SIZE != 32'h0) && (erel < {32'h0, ERR_SIZE});
    assign size_bad = i_hsize > 3'(LANE_W);
    assign misalign = (i_haddr & ((32'h1 << i_hsize) - 32'h1)) != 32'h0;
    assign err_a    = !in_mem || in_err || size_bad || misalign;
    assign accept   = i_hsel && i_hreadyin && o_hready && i_htrans[1];

    assign unused_hburst = ^i_hburst;

    assign in_data  = (state == ST_DATA);
    assign o_hready = ready_q && !(in_data && i_stall);
    assign o_hresp  = {1'b0, resp_q};
    assign o_hrdata = (in_data && !write_p1) ? mem[idx_p1] : '0;
    assign mem_we   = in_data && write_p1 && o_hready;

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state    <= ST_IDLE;
            wcnt     <= 4'd0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
            idx_p1   <= '0;
            be_p1    <= '0;
            write_p1 <= 1'b0;
        end else if (state == ST_ERR1) begin
            state   <= ST_ERR2;
            ready_q <= 1'b1;
            resp_q  <= 1'b1;
        end else if (in_data && !o_hready) begin
            // ready_q tracks wcnt==0 for the following cycle; stall is folded in combinationally
            wcnt    <= sat_dec(wcnt);
            ready_q <= (wcnt <= 4'd1);
        end else if (accept) begin
            idx_p1   <= rel[IDX_W+LANE_W-1:LANE_W];
            be_p1    <= lane_enable(i_haddr[LANE_W-1:0], i_hsize);
            write_p1 <= i_hwrite;
            if (err_a) begin
                state   <= ST_ERR1;
                wcnt    <= 4'd0;
                ready_q <= 1'b0;
                resp_q  <= 1'b1;
            end else begin
                state   <= ST_DATA;
                wcnt    <= 4'(WAIT_STATES);
                ready_q <= (WAIT_STATES == 0);
                resp_q  <= 1'b0;
            end
        end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
        end
    end

    // Data phase: contents survive reset, only enabled lanes change
    always_ff @(posedge i_hclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++)
                if (be_p1[b])
                    mem[idx_p1][b*8 +: 8] <= i_hwdata[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Bench for ahb_subordinate_mem: a 64-bit zero-wait instance with an error window and a
// 32-bit three-wait instance, both checked against a byte-addressed reference memory.
module tb_ahb_subordinate_mem;
    logic         clk = 1'b0;
    logic         rst;
    logic         sel_a, sel_b;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [2:0]   hburst;
    logic [127:0] hwdata;
    logic         stall;
    logic [63:0]  rdata_a;
    logic         rdy_a;
    logic [1:0]   resp_a;
    logic [31:0]  rdata_b;
    logic         rdy_b;
    logic [1:0]   resp_b;
    logic         hreadyin;
    int           cur;
    int           total;
    int           bad;

    typedef struct {
        logic         sel;
        logic [1:0]   trans;
        logic [31:0]  addr;
        logic         wr;
        logic [2:0]   size;
        logic [127:0] wdata;
        int           stall_hi;
    } xfer_t;

    xfer_t      q[$];
    logic [7:0] mm [2][128];

    always #5 clk = ~clk;
    assign hreadyin = (cur == 0) ? rdy_a : rdy_b;

    ahb_subordinate_mem #(
        .DATA_WDT(64), .MEM_DEPTH(16), .BASE_ADDR(32'h3FF00), .WAIT_STATES(0),
        .ERR_BASE(32'h3FF40), .ERR_SIZE(32'h10)
    ) u_a (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(sel_a), .i_hreadyin(hreadyin),
        .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
        .i_hburst(hburst), .i_hwdata(hwdata[63:0]), .i_stall(stall),
        .o_hrdata(rdata_a), .o_hready(rdy_a), .o_hresp(resp_a)
    );

    ahb_subordinate_mem #(
        .DATA_WDT(32), .MEM_DEPTH(8), .BASE_ADDR(32'h0), .WAIT_STATES(3),
        .ERR_BASE(32'h0), .ERR_SIZE(32'h0)
    ) u_b (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(sel_b), .i_hreadyin(hreadyin),
        .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
        .i_hburst(hburst), .i_hwdata(hwdata[31:0]), .i_stall(stall),
        .o_hrdata(rdata_b), .o_hready(rdy_b), .o_hresp(resp_b)
    );

    function automatic longint base_of(int d);  return d ? 64'h0 : 64'h3FF00; endfunction
    function automatic int     bytes_of(int d); return d ? 4 : 8;             endfunction
    function automatic int     depth_of(int d); return d ? 8 : 16;            endfunction
    function automatic int     lg_of(int d);    return d ? 2 : 3;             endfunction
    function automatic int     ws_of(int d);    return d ? 3 : 0;             endfunction
    function automatic longint errb_of(int d);  return d ? 64'h0 : 64'h3FF40; endfunction
    function automatic longint errs_of(int d);  return d ? 64'h0 : 64'h10;    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Illegal access rules expressed directly on byte addresses
    function automatic bit exp_err(int d, logic [31:0] addr, logic [2:0] size);
        longint a = longint'(addr);
        bit e = 1'b0;
        if (a < base_of(d) || a >= base_of(d) + bytes_of(d) * depth_of(d)) e = 1'b1;
        if (errs_of(d) != 0 && a >= errb_of(d) && a < errb_of(d) + errs_of(d)) e = 1'b1;
        if (int'(size) > lg_of(d)) e = 1'b1;
        if (a % (longint'(1) << size) != 0) e = 1'b1;
        return e;
    endfunction

    function automatic logic [127:0] model_word(int d, logic [31:0] addr);
        logic [127:0] w = '0;
        int off = int'(longint'(addr) - base_of(d));
        int wb = off - off % bytes_of(d);
        for (int b = 0; b < bytes_of(d); b++) w[b*8 +: 8] = mm[d][wb + b];
        return w;
    endfunction

    task automatic model_write(int d, logic [31:0] addr, logic [2:0] size, logic [127:0] wdata);
        int off = int'(longint'(addr) - base_of(d));
        int lane = off % bytes_of(d);
        for (int i = 0; i < (1 << size); i++) mm[d][off + i] = wdata[(lane + i)*8 +: 8];
    endtask

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(logic sel, logic [1:0] trans, logic [31:0] addr, logic wr,
                                 logic [2:0] size, logic [127:0] wdata, int stall_hi);
        xfer_t it;
        it.sel = sel; it.trans = trans; it.addr = addr; it.wr = wr;
        it.size = size; it.wdata = wdata; it.stall_hi = stall_hi;
        return it;
    endfunction

    function automatic xfer_t rand_item(int d);
        xfer_t it;
        int r = $urandom_range(0, 9);
        it.sel = ($urandom_range(0, 9) != 0);
        it.trans = (r < 5) ? 2'd2 : (r < 7) ? 2'd3 : (r < 8) ? 2'd1 : 2'd0;
        it.size = 3'($urandom_range(0, lg_of(d) + 1));
        it.addr = 32'(base_of(d)) - 32'(bytes_of(d))
                + 32'($urandom_range(0, bytes_of(d) * (depth_of(d) + 2) - 1));
        if ($urandom_range(0, 3) != 0) it.addr = it.addr & ~((32'h1 << it.size) - 32'h1);
        it.wr = 1'($urandom_range(0, 1));
        it.wdata = rnd128();
        it.stall_hi = $urandom_range(0, ws_of(d) + 3);
        return it;
    endfunction

    task automatic drive(int d, xfer_t it);
        sel_a  = (d == 0) && it.sel;
        sel_b  = (d == 1) && it.sel;
        haddr  = it.addr;
        htrans = it.trans;
        hwrite = it.wr;
        hsize  = it.size;
        hburst = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle();
        sel_a = 1'b0; sel_b = 1'b0; htrans = 2'd0; haddr = $urandom();
        hwrite = 1'($urandom_range(0, 1)); hsize = 3'd0; hburst = 3'd0;
    endtask

    // Plays the queue on one instance, presenting each address as soon as the bus is ready
    task automatic run(input int d);
        xfer_t dp, it;
        bit have_dp = 1'b0, dp_err = 1'b0, had, done = 1'b0;
        int k = 0;
        logic [127:0] e_rd, o_rd;
        logic e_rdy, o_rdy;
        logic [1:0] e_resp, o_resp;
        string s = d ? "B" : "A";
        cur = d;
        while (!done) begin
            @(negedge clk);
            if (have_dp) begin
                stall  = (k < dp.stall_hi);
                hwdata = dp.wr ? dp.wdata : rnd128();
            end else begin
                stall  = 1'($urandom_range(0, 1));
                hwdata = rnd128();
            end
            #1;
            e_rd = '0; e_rdy = 1'b1; e_resp = 2'd0;
            if (have_dp && dp_err) begin
                e_rdy = (k == 1); e_resp = 2'd1;
            end else if (have_dp) begin
                e_rdy = (k >= ws_of(d)) && !stall;
                if (!dp.wr) e_rd = model_word(d, dp.addr);
            end
            o_rdy  = d ? rdy_b : rdy_a;
            o_resp = d ? resp_b : resp_a;
            o_rd   = d ? {96'h0, rdata_b} : {64'h0, rdata_a};
            check({s, "_hready"}, o_rdy, e_rdy);
            check({s, "_hresp"}, o_resp, e_resp);
            check({s, "_hrdata"}, o_rd, e_rd);
            had = have_dp;
            if (o_rdy) begin
                if (have_dp && dp.wr && !dp_err) model_write(d, dp.addr, dp.size, dp.wdata);
                if (q.size() > 0) begin
                    it = q.pop_front();
                    drive(d, it);
                    have_dp = it.sel && it.trans[1];
                    dp = it;
                    dp_err = exp_err(d, it.addr, it.size);
                    k = 0;
                end else begin
                    drive_idle();
                    have_dp = 1'b0;
                    if (!had) done = 1'b1;
                end
            end else begin
                k++;
                if (k > 40) begin
                    $display("FAIL %s_timeout: data phase still open after %0d cycles", s, k);
                    $display("test done: total=%0d bad=%0d", total, bad + 1);
                    $fatal(1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cur = 0;
        rst = 1'b1; stall = 1'b0; hwdata = '0;
        drive_idle();
        for (int d = 0; d < 2; d++) for (int i = 0; i < 128; i++) mm[d][i] = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_A_hready", rdy_a, 1'b1);
        check("rst_A_hresp", resp_a, 2'd0);
        check("rst_A_hrdata", rdata_a, 64'h0);
        check("rst_B_hready", rdy_b, 1'b1);
        check("rst_B_hresp", resp_b, 2'd0);
        check("rst_B_hrdata", rdata_b, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) q.push_back(mk(1, 2'd2, 32'h3FF00 + 32'(i*8), 1, 3'd3, 128'(i), 0));
        for (int i = 0; i < 16; i++)
            q.push_back(mk(1, (i == 0) ? 2'd2 : 2'd3, 32'h3FF00 + 32'(i*8), 0, 3'd3, '0, 0));
        run(0);

        q.push_back(mk(1, 2'd2, 32'h3FF05, 1, 3'd0, 128'hAB << 40, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF00, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF01, 1, 3'd1, rnd128(), 1));
        q.push_back(mk(1, 2'd2, 32'h3FF00, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF80, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF44, 1, 3'd2, rnd128(), 2));
        q.push_back(mk(1, 2'd2, 32'h3FF40, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FEF8, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF00, 0, 3'd4, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF04, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF08, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF7F, 0, 3'd0, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF18, 1, 3'd3, 128'h0123_4567_89AB_CDEF, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF18, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF20, 1, 3'd2, rnd128(), 0));
        q.push_back(mk(1, 2'd1, 32'h3FF28, 1, 3'd3, rnd128(), 0));
        q.push_back(mk(1, 2'd3, 32'h3FF20, 0, 3'd3, '0, 0));
        q.push_back(mk(0, 2'd2, 32'h3FF20, 1, 3'd3, rnd128(), 0));
        q.push_back(mk(1, 2'd2, 32'h3FF20, 0, 3'd3, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h3FF26, 1, 3'd1, rnd128(), 0));
        q.push_back(mk(1, 2'd2, 32'h3FF20, 0, 3'd3, '0, 0));
        run(0);

        repeat (60) q.push_back(rand_item(0));
        run(0);

        for (int i = 0; i < 8; i++) q.push_back(mk(1, 2'd2, 32'(i*4), 1, 3'd2, 128'h1111_0000 + 128'(i), 0));
        q.push_back(mk(1, 2'd2, 32'h4, 0, 3'd2, '0, 0));
        q.push_back(mk(1, 2'd2, 32'h4, 0, 3'd2, '0, 5));
        q.push_back(mk(1, 2'd2, 32'h20, 0, 3'd2, '0, 3));
        run(1);

        repeat (40) q.push_back(rand_item(1));
        run(1);

        // Reset lands on the completing edge of a three-wait write to word 2
        cur = 1;
        @(negedge clk);
        drive(1, mk(1, 2'd2, 32'h8, 1, 3'd2, 128'hDEAD_BEEF, 0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive_idle();
            stall = 1'b0;
            hwdata = 128'hDEAD_BEEF;
            #1;
            check("rstw_B_hready", rdy_b, (k == 3));
        end
        #1 rst = 1'b1;
        #1;
        check("rstw_B_hready_async", rdy_b, 1'b1);
        check("rstw_B_hresp_async", resp_b, 2'd0);
        check("rstw_B_hrdata_async", rdata_b, 32'h0);
        check("rstw_A_hready_async", rdy_a, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(mk(1, (i == 0) ? 2'd2 : 2'd3, 32'(i*4), 0, 3'd2, '0, 0));
        run(1);
        for (int i = 0; i < 16; i++) q.push_back(mk(1, 2'd2, 32'h3FF00 + 32'(i*8), 0, 3'd3, '0, 0));
        run(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
